// File: rtl/alu32_arbiter_if.sv
// Bundles the two requester ports, the alu32 control/data lines and the response port.
// The arbiter uses the slave view; the driving environment uses the master view.
interface alu32_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic             alu_A_invert;
    logic             alu_B_invert;
    logic             alu_cin;
    logic [1:0]       alu_operation;
    logic             alu_less;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_src1, alu_src2, alu_A_invert, alu_B_invert, alu_cin, alu_operation, alu_less,
        input  alu_result, alu_cout,
        output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_src1, alu_src2, alu_A_invert, alu_B_invert, alu_cin, alu_operation, alu_less,
        output alu_result, alu_cout,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu32_arbiter.sv
// Round-robin front end sharing one combinational alu32 between two requesters.
// Latches an operation, sequences the ALU (two passes for SLT) and holds a registered response.
module alu32_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu32_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_SLT2 = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_supported = 1'b1;
            default:                                      op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_has_carry(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: op_has_carry = 1'b1;
            default:        op_has_carry = 1'b0;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             set_q, set_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt0_s, gnt1_s;
    logic             ready0_s, ready1_s;
    logic             slt_set_s;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt0_s = rr_last_q;
            gnt1_s = ~rr_last_q;
        end else begin
            gnt0_s = bus.req0_valid;
            gnt1_s = bus.req1_valid;
        end
        ready0_s = (state_q == ST_IDLE) && gnt0_s;
        ready1_s = (state_q == ST_IDLE) && gnt1_s;
    end

    // Overflow-corrected sign of a-b from the first SLT pass.
    always_comb begin
        slt_set_s = bus.alu_result[WIDTH-1] ^
                    ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ bus.alu_result[WIDTH-1]));
    end

    // Sequencer next-state and response capture.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        set_d       = set_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (ready0_s || ready1_s) begin
                    op_d      = ready1_s ? bus.req1_op : bus.req0_op;
                    a_d       = ready1_s ? bus.req1_a  : bus.req0_a;
                    b_d       = ready1_s ? bus.req1_b  : bus.req0_b;
                    id_d      = ready1_s;
                    rr_last_d = ready1_s;
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (!op_supported(op_q)) begin
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_cout_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (op_q == OP_SLT) begin
                    set_d       = slt_set_s;
                    state_d     = ST_SLT2;
                end else begin
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = bus.alu_result;
                    rsp_cout_d  = op_has_carry(op_q) & bus.alu_cout;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_SLT2: begin
                rsp_err_d   = 1'b0;
                rsp_data_d  = bus.alu_result;
                rsp_cout_d  = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            op_q        <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            set_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            set_q       <= set_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // ALU control decoded purely from registered state; quiet outside EXEC/SLT2.
    always_comb begin
        bus.alu_src1      = '0;
        bus.alu_src2      = '0;
        bus.alu_A_invert  = 1'b0;
        bus.alu_B_invert  = 1'b0;
        bus.alu_cin       = 1'b0;
        bus.alu_operation = 2'b00;
        bus.alu_less      = 1'b0;
        case (state_q)
            ST_EXEC: begin
                if (!op_supported(op_q)) begin
                    bus.alu_src1 = '0;
                end else if (op_q == OP_SLT) begin
                    bus.alu_src1      = a_q;
                    bus.alu_src2      = b_q;
                    bus.alu_B_invert  = 1'b1;
                    bus.alu_cin       = 1'b1;
                    bus.alu_operation = 2'b10;
                end else begin
                    bus.alu_src1      = a_q;
                    bus.alu_src2      = b_q;
                    bus.alu_A_invert  = op_q[3];
                    bus.alu_B_invert  = op_q[2];
                    bus.alu_cin       = op_q[2];
                    bus.alu_operation = op_q[1:0];
                end
            end
            ST_SLT2: begin
                bus.alu_src1      = a_q;
                bus.alu_src2      = b_q;
                bus.alu_B_invert  = 1'b1;
                bus.alu_cin       = 1'b1;
                bus.alu_operation = 2'b11;
                bus.alu_less      = set_q;
            end
            default: begin
                bus.alu_src1 = '0;
            end
        endcase
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule
